// File: rtl/mod_muldiv.sv
// rtl/mod_muldiv.sv - multi-cycle multiply/divide unit with architectural HI/LO registers
module mod_muldiv #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        we_hi,
    input  logic        we_lo,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [3:0] MULT_LAT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LAT  = 4'(DIV_CYCLES);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] res_hi_q, res_hi_d;
    logic [31:0] res_lo_q, res_lo_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        retire;
    logic        accept;

    // A start may land on the retire edge so back-to-back issues keep busy high.
    assign retire = (state_q == S_RUN) && (cnt_q == 4'd1);
    assign accept = start && ((state_q == S_IDLE) || retire);

    logic [63:0] a_ext, b_ext, prod;

    always_comb begin
        a_ext = op[0] ? {32'b0, src_a} : {{32{src_a[31]}}, src_a};
        b_ext = op[0] ? {32'b0, src_b} : {{32{src_b[31]}}, src_b};
        prod  = a_ext * b_ext;
    end

    logic        a_neg, b_neg, b_zero;
    logic [31:0] mag_a, mag_b, div_b;
    logic [31:0] uq, ur, quot, rem;

    // Magnitude division; the 0x80000000 / -1 case wraps back to 0x80000000 with rem 0.
    always_comb begin
        a_neg  = ~op[0] & src_a[31];
        b_neg  = ~op[0] & src_b[31];
        b_zero = (src_b == 32'd0);
        mag_a  = a_neg ? -src_a : src_a;
        mag_b  = b_neg ? -src_b : src_b;
        div_b  = b_zero ? 32'd1 : mag_b;
        uq     = mag_a / div_b;
        ur     = mag_a % div_b;
        quot   = (a_neg ^ b_neg) ? -uq : uq;
        rem    = a_neg ? -ur : ur;
        if (b_zero) begin
            quot = 32'hFFFF_FFFF;
            rem  = src_a;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            res_hi_q <= 32'd0;
            res_lo_q <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = op[1] ? DIV_LAT : MULT_LAT;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    if (start) begin
                        state_d = S_RUN;
                        cnt_d   = op[1] ? DIV_LAT : MULT_LAT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_comb begin
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        if (accept) begin
            if (op[1]) begin
                res_hi_d = rem;
                res_lo_d = quot;
            end else begin
                res_hi_d = prod[63:32];
                res_lo_d = prod[31:0];
            end
        end
        if (retire) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
        end else if ((state_q == S_IDLE) && !start) begin
            if (we_hi) hi_d = src_a;
            if (we_lo) lo_d = src_a;
        end
    end

    assign busy = (state_q == S_RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
